// File: rtl/add_result_stage.sv
// add_result_stage: narrows the adder's N+1-bit sum to N bits (wrap or saturate), flags it,
// tracks sticky overflow and buffers entries in a 2-deep valid/ready FIFO.
module add_result_stage #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N:0]   in_sum,
    input  logic         sat_en,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_ovf,
    output logic         out_zero,
    output logic         out_neg,
    input  logic         clr_sticky,
    output logic         sticky_ovf
);
    localparam int W = N + 3;

    logic [W-1:0] mem_q [2];
    logic [1:0]   count_q, count_d;
    logic         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic         sticky_q, sticky_d;
    logic         push, pop, ovf;
    logic [N-1:0] data;
    logic [W-1:0] entry, head;

    // Entries are narrowed and flagged on the way in so the output side is purely registered
    always_comb begin
        ovf = in_sum[N] ^ in_sum[N-1];
        data = (ovf && sat_en) ? (in_sum[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}})
                               : in_sum[N-1:0];
        entry = {data, ovf, data == '0, data[N-1]};
    end

    assign in_ready  = !rst && (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem_q[rd_ptr_q];

    // Fields read as zero while empty so no stale entry is ever presented
    assign {out_data, out_ovf, out_zero, out_neg} = out_valid ? head : '0;
    assign sticky_ovf = sticky_q;

    always_comb begin
        count_d  = (push && !pop) ? count_q + 2'd1 : (pop && !push) ? count_q - 2'd1 : count_q;
        wr_ptr_d = push ? !wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop ? !rd_ptr_q : rd_ptr_q;
        sticky_d = (push && ovf) ? 1'b1 : clr_sticky ? 1'b0 : sticky_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            if (push)
                mem_q[wr_ptr_q] <= entry;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sticky_q <= sticky_d;
        end
    end
endmodule

// File: tb/tb_add_result_stage.sv
// tb_add_result_stage: random and directed stimulus against an integer-arithmetic model,
// expected entries queued at push and checked by an independent output monitor.
module tb_add_result_stage;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N:0]   in_sum = '0;
    logic         sat_en = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_data;
    logic         out_ovf, out_zero, out_neg;
    logic         clr_sticky = 1'b0;
    logic         sticky_ovf;

    int checks = 0;
    int errors = 0;
    logic [N+2:0] exp_q[$];
    logic         sticky_m = 1'b0;
    logic         acc;

    add_result_stage #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
        .sat_en(sat_en), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_zero(out_zero), .out_neg(out_neg),
        .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf)
    );

    always #5 clk = ~clk;

    // Entry = {data, ovf, zero, neg}, derived from the signed value and the N-bit range
    function automatic logic [N+2:0] model(input logic [N:0] s, input logic sat);
        int v, r, lo, hi;
        logic o;
        logic [N-1:0] d;
        v  = $signed(s);
        lo = -(1 << (N - 1));
        hi = (1 << (N - 1)) - 1;
        o  = (v < lo) || (v > hi);
        r  = (o && sat) ? ((v < lo) ? lo : hi) : v;
        d  = r[N-1:0];
        return {d, o, d == 0, d[N-1]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cycle(input logic v, input logic [N:0] s, input logic sat,
                         input logic ordy, input logic clr, output logic a);
        logic [N+2:0] e;
        @(negedge clk);
        chk("in_ready", in_ready, exp_q.size() != 2);
        chk("out_valid", out_valid, exp_q.size() != 0);
        chk("sticky_ovf", sticky_ovf, sticky_m);
        in_valid = v; in_sum = s; sat_en = sat; out_ready = ordy; clr_sticky = clr;
        #1;
        a = v && (exp_q.size() != 2);
        e = model(s, sat);
        if (a) exp_q.push_back(e);
        sticky_m = (a && e[2]) ? 1'b1 : clr ? 1'b0 : sticky_m;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got data %0h, expected nothing at %0t", out_data, $time);
                end else
                    chk("entry", {out_data, out_ovf, out_zero, out_neg}, exp_q.pop_front());
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("post-rst in_ready", in_ready, 1);
        chk("post-rst out_valid", out_valid, 0);
        chk("post-rst outs", {out_data, out_ovf, out_zero, out_neg, sticky_ovf}, 0);
        // saturate and wrap cases, one entry at a time
        cycle(1, 5'b01000, 1, 1, 0, acc);
        cycle(1, 5'b10111, 1, 1, 0, acc);
        cycle(1, 5'b01000, 0, 1, 0, acc);
        cycle(1, 5'b10000, 0, 1, 0, acc);
        cycle(1, 5'b00011, 0, 1, 1, acc);
        cycle(0, 0, 0, 1, 0, acc);
        cycle(0, 0, 0, 1, 0, acc);
        // sticky: clear coincident with overflowing push, then clear alone
        cycle(1, 5'b01100, 0, 1, 1, acc);
        cycle(0, 0, 0, 1, 1, acc);
        cycle(0, 0, 0, 1, 0, acc);
        // backpressure: 3 is held off until a pop frees a slot
        cycle(1, 5'd1, 0, 0, 0, acc);
        cycle(1, 5'd2, 0, 0, 0, acc);
        cycle(1, 5'd3, 0, 0, 0, acc);
        chk("third push refused", acc, 0);
        acc = 1'b0;
        for (int i = 0; i < 6 && !acc; i++) cycle(1, 5'd3, 0, 1, 0, acc);
        chk("third push accepted", acc, 1);
        repeat (3) cycle(0, 0, 0, 1, 0, acc);
        // streaming: in_ready never drops, so occupancy stays at most 1
        for (int i = 0; i < 20; i++) cycle(1, 5'($urandom), 1'($urandom), 1, 0, acc);
        repeat (2) cycle(0, 0, 0, 1, 0, acc);
        // reset with two held entries and sticky set
        cycle(1, 5'b01000, 0, 0, 0, acc);
        cycle(1, 5'b10100, 0, 0, 0, acc);
        cycle(0, 0, 0, 0, 0, acc);
        chk("pre-rst sticky", sticky_ovf, 1);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_sum = 5'b01111; out_ready = 1'b1;
        #1;
        chk("mid-rst in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        sticky_m = 1'b0;
        #1;
        chk("after-rst out_valid", out_valid, 0);
        chk("after-rst sticky", sticky_ovf, 0);
        chk("after-rst in_ready", in_ready, 1);
        repeat (3) cycle(0, 0, 0, 1, 0, acc);
        // random traffic with random stalls and clears
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom), 5'($urandom), 1'($urandom), ($urandom % 4) != 0, ($urandom % 8) == 0, acc);
        repeat (4) cycle(0, 0, 0, 1, 0, acc);
        chk("drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
